// File: rtl/seq_tx_pkg.sv
// seq_tx_pkg: shared state encoding, default sizes and len legality check for the pattern transmitter
package seq_tx_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SEND  = 2'b01,
    GAP_S = 2'b10
  } state_t;
  localparam int W_DEF   = 8;
  localparam int CW_DEF  = 4;
  localparam int GAP_DEF = 1;
  function automatic logic len_bad(input int unsigned l, input int unsigned w);
    return l == 0 || l > w;
  endfunction
endpackage

// File: rtl/seq_pattern_tx_if.sv
// seq_pattern_tx_if: start/stop control, pattern inputs and serial outputs of the transmitter
interface seq_pattern_tx_if import seq_tx_pkg::*; #(
  parameter int W  = W_DEF,
  parameter int LW = $clog2(W) + 1,
  parameter int CW = CW_DEF
) ();
  logic          start;
  logic          stop;
  logic [W-1:0]  pattern;
  logic [LW-1:0] len;
  logic [CW-1:0] reps;
  logic          signal;
  logic          sig_valid;
  logic          busy;
  logic          done;
  logic          err;
  modport master (output start, stop, pattern, len, reps, input signal, sig_valid, busy, done, err);
  modport slave (input start, stop, pattern, len, reps, output signal, sig_valid, busy, done, err);
endinterface

// File: rtl/seq_tx_shreg.sv
// seq_tx_shreg: left shifter holding the pattern MSB-aligned, counting down the bits of one repetition
module seq_tx_shreg #(
  parameter int W  = 8,
  parameter int LW = $clog2(W) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          shift,
  input  logic [W-1:0]  din,
  input  logic [LW-1:0] len,
  output logic          msb,
  output logic          last_bit
);
  logic [W-1:0]  sr;
  logic [LW-1:0] cnt;
  // load aligns bit len-1 to the MSB so every pattern leaves from the same end
  always_ff @(posedge clk) begin
    if (!rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= din << (LW'(W) - len);
      cnt <= len;
    end else if (shift) begin
      sr  <= sr << 1;
      cnt <= cnt - LW'(1);
    end
  end
  assign msb      = sr[W-1];
  assign last_bit = cnt == LW'(1);
endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial pattern transmitter with repetition, inter-rep gap and sticky stop
module seq_pattern_tx import seq_tx_pkg::*; #(
  parameter int W   = W_DEF,
  parameter int LW  = $clog2(W) + 1,
  parameter int CW  = CW_DEF,
  parameter int GAP = GAP_DEF
) (
  input logic            clk,
  input logic            rst,
  seq_pattern_tx_if.slave bus
);
  localparam int GW = GAP > 1 ? $clog2(GAP) : 1;
  state_t        state, nxt;
  logic [W-1:0]  pat_q;
  logic [LW-1:0] len_q;
  logic [CW-1:0] rep_cnt;
  logic [GW-1:0] gcnt;
  logic          inf_q, stop_q, done_q, err_q;
  logic          load, shift, msb, last_bit;
  logic          accept, reject, fin, stop_seen, gap_end;
  assign accept    = state == IDLE && bus.start && !len_bad(32'(bus.len), W);
  assign reject    = state == IDLE && bus.start && len_bad(32'(bus.len), W);
  assign fin       = !inf_q && rep_cnt == CW'(1);
  assign stop_seen = stop_q | bus.stop;
  assign gap_end   = gcnt == GW'(GAP - 1);
  seq_tx_shreg #(.W(W), .LW(LW)) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift    (shift),
    .din      (state == IDLE ? bus.pattern : pat_q),
    .len      (state == IDLE ? bus.len : len_q),
    .msb      (msb),
    .last_bit (last_bit)
  );
  // state register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end
  // next state: a repetition always runs to its last bit before stop or the final count is honoured
  always_comb begin
    nxt   = state;
    load  = 1'b0;
    shift = 1'b0;
    case (state)
      IDLE: begin
        nxt  = accept ? SEND : IDLE;
        load = accept;
      end
      SEND: begin
        shift = 1'b1;
        if (last_bit) begin
          nxt  = fin || stop_seen ? IDLE : (GAP == 0 ? SEND : GAP_S);
          load = !(fin || stop_seen) && GAP == 0;
        end
      end
      GAP_S: begin
        nxt  = gap_end ? (stop_seen ? IDLE : SEND) : GAP_S;
        load = gap_end && !stop_seen;
      end
      default: nxt = IDLE;
    endcase
  end
  // captured request, rep/gap counters, sticky stop and the done/err pulses
  always_ff @(posedge clk) begin
    if (!rst) begin
      pat_q   <= '0;
      len_q   <= '0;
      rep_cnt <= '0;
      inf_q   <= 1'b0;
      gcnt    <= '0;
      stop_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        pat_q   <= bus.pattern;
        len_q   <= bus.len;
        rep_cnt <= bus.reps;
        inf_q   <= bus.reps == '0;
      end else if (state == SEND && last_bit && !inf_q) begin
        rep_cnt <= rep_cnt - CW'(1);
      end
      gcnt   <= state == GAP_S ? gcnt + GW'(1) : '0;
      stop_q <= state != IDLE && nxt != IDLE && stop_seen;
      done_q <= state != IDLE && nxt == IDLE;
      err_q  <= reject;
    end
  end
  assign bus.signal    = msb & (state == SEND);
  assign bus.sig_valid = state == SEND;
  assign bus.busy      = state != IDLE;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: random and directed frames on GAP=1 and GAP=0 transmitters against a frame-level model
module tb_seq_pattern_tx;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, stop = 1'b0, sel = 1'b1;
  logic [W-1:0] pattern = '0;
  logic [3:0] len = '0, reps = '0;
  int n_chk = 0, n_fail = 0;
  int l, r, s, total, g;
  logic [4:0] exp_q[$];
  logic [4:0] o1, o0, obs;
  always #5 clk = ~clk;
  seq_pattern_tx_if b1 ();
  seq_pattern_tx_if b0 ();
  assign b1.start = start && sel;
  assign b0.start = start && !sel;
  assign b1.stop = stop;
  assign b0.stop = stop;
  assign b1.pattern = pattern;
  assign b0.pattern = pattern;
  assign b1.len = len;
  assign b0.len = len;
  assign b1.reps = reps;
  assign b0.reps = reps;
  assign o1 = {b1.signal, b1.sig_valid, b1.busy, b1.done, b1.err};
  assign o0 = {b0.signal, b0.sig_valid, b0.busy, b0.done, b0.err};
  assign obs = sel ? o1 : o0;
  seq_pattern_tx #(.GAP(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  seq_pattern_tx #(.GAP(0)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (sig,vld,busy,done,err) at %0t", tag, got[4:0], want[4:0], $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic build(input logic [W-1:0] p, input int ln, input int rp, input int sc, input int gp);
    int t, rep;
    exp_q.delete();
    if (ln < 1 || ln > W) begin
      exp_q.push_back(5'b00001);
      return;
    end
    t = 0;
    rep = 0;
    while (t < 2000) begin
      for (int i = ln - 1; i >= 0; i--) begin
        exp_q.push_back({p[i], 4'b1100});
        t++;
      end
      rep++;
      if ((rp != 0 && rep == rp) || (sc >= 1 && sc <= t)) break;
      for (int i = 0; i < gp; i++) begin
        exp_q.push_back(5'b00100);
        t++;
      end
      if (sc >= 1 && sc <= t) break;
    end
    exp_q.push_back(5'b00010);
  endtask
  task automatic run_tx(input logic sv, input logic [W-1:0] p, input int ln, input int rp, input int sc,
                        input logic stop0, input logic junk);
    sel = sv;
    start = 1'b1;
    pattern = p;
    len = 4'(ln);
    reps = 4'(rp);
    stop = stop0;
    build(p, ln, rp, sc, sv ? 1 : 0);
    for (int c = 1; c <= exp_q.size(); c++) begin
      step();
      chk($sformatf("tx%0d_c%0d", sv, c), {3'b0, obs}, {3'b0, exp_q[c-1]});
      start = 1'b0;
      stop = c == sc;
      if (junk && exp_q[c-1][2]) begin
        start = 1'($urandom_range(0, 1));
        pattern = W'($urandom);
        len = 4'($urandom_range(0, 15));
        reps = 4'($urandom);
      end
    end
    start = 1'b0;
    stop = 1'b0;
  endtask
  initial begin
    repeat (2) step();
    chk("reset_u1", {3'b0, o1}, 8'h00);
    chk("reset_u0", {3'b0, o0}, 8'h00);
    rst = 1'b1;
    step();
    chk("idle_after_reset", {3'b0, obs}, 8'h00);
    run_tx(1'b1, 8'b0000_0101, 3, 1, 0, 1'b0, 1'b0);
    run_tx(1'b1, 8'b0000_0101, 3, 2, 0, 1'b0, 1'b0);
    run_tx(1'b0, 8'b0000_0101, 3, 0, 5, 1'b0, 1'b0);
    run_tx(1'b1, 8'hff, 0, 1, 0, 1'b0, 1'b0);
    run_tx(1'b1, 8'hff, W + 1, 1, 0, 1'b0, 1'b0);
    run_tx(1'b1, 8'hA5, 8, 2, 0, 1'b0, 1'b1);
    run_tx(1'b0, 8'h01, 1, 0, 10, 1'b0, 1'b0);
    run_tx(1'b1, 8'h0D, 4, 0, 6, 1'b0, 1'b0);
    run_tx(1'b1, 8'h36, 6, 2, 0, 1'b1, 1'b0);
    run_tx(1'b0, 8'h9C, 8, 15, 0, 1'b0, 1'b0);
    sel = 1'b1;
    pattern = 8'b0000_0101;
    len = 4'd3;
    reps = 4'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("rst_bit1", {3'b0, obs}, 8'b000_11100);
    step();
    chk("rst_bit2", {3'b0, obs}, 8'b000_01100);
    rst = 1'b0;
    step();
    chk("rst_abandon", {3'b0, obs}, 8'h00);
    rst = 1'b1;
    step();
    chk("rst_no_done", {3'b0, obs}, 8'h00);
    run_tx(1'b1, 8'b0000_0101, 3, 1, 0, 1'b0, 1'b0);
    repeat (150) begin
      g = $urandom_range(0, 1);
      l = $urandom_range(0, 9) == 0 ? ($urandom_range(0, 1) ? 0 : $urandom_range(W + 1, 15)) : $urandom_range(1, W);
      r = $urandom_range(0, 4);
      total = r * l + (r > 0 ? (r - 1) * g : 0);
      s = r == 0 ? $urandom_range(1, 3 * (l + g) + 1) : ($urandom_range(0, 1) ? $urandom_range(1, total) : 0);
      run_tx(1'(g), W'($urandom), l, r, s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        step();
        chk("idle_gap", {3'b0, obs}, 8'h00);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
- Serial pattern transmitter. Emits a programmable bit pattern, MSB-first, one bit per clock on a single serial line.
- Acts as the generating end for the team's serial sequence detectors, for example emitting "101" frames with controlled gaps and repetition.
- Sits between a control/test harness (start handshake) and any single-bit serial consumer.
- Moore style: every output is registered and depends only on state.

Parameters:
- W, 8: maximum pattern length in bits.
- LW, $clog2(W)+1: width of the len port.
- CW, 4: width of the repetition count.
- GAP, 1: idle cycles inserted between repetitions. 0 means back-to-back.

Ports:
- clk  in  1  system clock; rising edge only.
- rst  in  1  reset; synchronous, active-low.
- start  in  1  request to transmit; sampled only in IDLE.
- pattern  in  W  pattern bits; bits [len-1:0] are sent, bit len-1 first.
- len  in  LW  number of pattern bits; legal range 1..W.
- reps  in  CW  number of repetitions; 0 means continuous until stop.
- stop  in  1  request to end continuous or multi-rep transmission.
- signal  out  1  serial output bit.
- sig_valid  out  1  high when signal carries a pattern bit.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when transmission completes.
- err  out  1  one-cycle pulse when a start with illegal len is rejected.

Behaviour:
- Reset (rst==0 at a rising edge): state=IDLE; signal, sig_valid, busy, done, err all 0; internal shift register, bit counter and rep counter cleared.
  - Applies mid-transmission: the frame is abandoned, with no done pulse.
- States: IDLE, SEND, GAP.
- IDLE:
  - start==1 with 1<=len<=W: capture pattern, len and reps; go to SEND.
  - start==1 with len==0 or len>W: err=1 for one cycle; stay in IDLE; nothing captured.
  - signal=0, sig_valid=0 throughout.
- Latency: start sampled at edge k, so the first bit pattern[len-1] is on signal and sig_valid=1 in the cycle after edge k.
  - Each bit is held exactly one cycle.
- SEND:
  - Shift left each cycle; the bit counter counts len bits.
  - After the last bit (pattern[0]) of a repetition, decrement the rep counter unless reps==0, then evaluate:
    - Final repetition, or stop seen: go to IDLE with done=1 in that first IDLE cycle.
    - Otherwise, GAP>0: go to GAP.
    - Otherwise (GAP==0): reload the pattern and stay in SEND; the next repetition's first bit follows with no bubble.
- GAP:
  - signal=0, sig_valid=0, busy=1 for exactly GAP cycles.
  - Then reload the captured pattern and go to SEND.
- stop:
  - Sticky: latched on any cycle while busy; cleared on entry to IDLE.
  - Never truncates a repetition; it takes effect at the end of the current repetition.
  - stop during GAP: return to IDLE at the end of GAP with done=1.
- start while busy: ignored; no err.
- start and stop together in IDLE: start accepted; stop ignored.
- Changes to pattern, len or reps after capture have no effect on the current transmission.
- len==1: one-bit repetitions. With GAP==0 and reps==0, signal equals pattern[0] constantly and sig_valid stays 1.
- reps==1: single frame.
- Rep counter width: CW bits, so a maximum of 2^CW-1 finite repetitions.

Decomposition:
- Shared package seq_tx_pkg holds:
  - state enum (IDLE=2'b00, SEND=2'b01, GAP=2'b10);
  - default W, CW and GAP constants;
  - an illegal-len check function.
- One natural sub-module, seq_tx_shreg:
  - W-bit loadable left-shift register with bit counter;
  - outputs the current MSB and a last_bit flag.
- The FSM, rep counter, gap counter and stop latch remain in the top level.

Test Plan:
- pattern=8'b0000_0101, len=3, reps=1, GAP=1; pulse start:
  - signal = 1,0,1 on cycles 1-3 with sig_valid=1;
  - done=1 in cycle 4; busy falls in cycle 4.
- Same pattern, reps=2, GAP=1:
  - signal 1,0,1,0,1,0,1;
  - sig_valid 1,1,1,0,1,1,1;
  - done in cycle 8.
- reps=0, GAP=0, len=3; assert stop in cycle 5:
  - second repetition completes, giving signal 1,0,1,1,0,1;
  - done in cycle 7; no truncation.
- len=0, and separately len=W+1, with start:
  - err pulses one cycle each time;
  - busy stays 0; signal stays 0.
- rst driven low during the bit-2 cycle of a frame:
  - next edge: all outputs 0, state IDLE, no done.
  - A new start after rst release transmits normally.
- start asserted again during SEND with a different pattern:
  - ignored; the original bit stream is unchanged; no err.
